// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared encodings for the memory port arbiter: FSM state codes,
//   access-owner codes and operation codes, plus the latched grant record.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef struct packed {
    logic owner;
    logic op;
  } grant_t;

  // Fetches are always reads; a data access is a write whenever the write
  // request is up, so a simultaneous read+write resolves to the write.
  function automatic logic pick_op(input logic own, input logic wr_req);
    return (own == OWN_D && wr_req) ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port (if_*), data port (d_*), memory port (m_*) and
//   the sticky protocol error flag.
//   slave  : the arbiter's view (requests and m_rdata in; readies, rdata,
//            memory controls and proto_err out).
//   master : the pipeline/memory side (the opposite directions).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_rd_req;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_rdata;
  logic              proto_err;

  modport slave (
    input  if_req, if_addr, d_rd_req, d_wr_req, d_addr, d_wdata, m_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
    output m_addr, m_wdata, m_read, m_write, proto_err
  );

  modport master (
    output if_req, if_addr, d_rd_req, d_wr_req, d_addr, d_wdata, m_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  m_addr, m_wdata, m_read, m_write, proto_err
  );
endinterface

// File: rtl/mem_port_arbiter_grant.sv
// mem_arb_grant
//   Picks the owner of the next memory access and keeps the starvation
//   counter that bounds how many data grants may pass a waiting fetch.
//   Ports: clk, rst (async, active-high)
//          i_if_req  fetch request present
//          i_d_req   data request present (read or write)
//          i_grant   strobe: a grant is being taken this cycle
//          o_own     owner choice (OWN_IF / OWN_D)
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_grant,
  output logic o_own
);

  localparam int            SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve_cnt;

  assign o_own = (i_d_req && (r_starve_cnt < LIM)) ? OWN_D : OWN_IF;

  // Only data grants that actually bypass a waiting fetch count toward
  // starvation; any other grant resets the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_grant) begin
      if (o_own == OWN_D && i_if_req) begin
        if (r_starve_cnt != LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-addressed big-endian 32-bit memory between the fetch
//   port and the data (LDR/STR) port. One access at a time: IDLE picks an
//   owner, BUSY holds address/controls for WAIT_CYCLES cycles, RESP pulses
//   the owner's ready for one cycle with the read data.
//   Ports: clk, rst (async, active-high)
//          bus  mem_port_arbiter_if.slave (fetch, data, memory, proto_err)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        r_state;
  grant_t            r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_proto_err;

  logic w_d_req;
  logic w_grant;
  logic w_own;
  logic w_busy;
  logic w_resp;
  logic w_if_ready;
  logic w_d_ready;

  assign w_d_req = bus.d_rd_req | bus.d_wr_req;
  assign w_grant = (r_state == ST_IDLE) && (w_d_req || bus.if_req);

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (bus.if_req),
    .i_d_req  (w_d_req),
    .i_grant  (w_grant),
    .o_own    (w_own)
  );

  // ---- IDLE -> BUSY: latch the winning request ----
  // ---- BUSY -> RESP: capture read data on the last wait cycle ----
  // ---- RESP -> IDLE ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_grant.owner <= w_own;
            r_grant.op    <= pick_op(w_own, bus.d_wr_req);
            r_addr        <= (w_own == OWN_D) ? bus.d_addr : bus.if_addr;
            r_wdata       <= (w_own == OWN_D) ? bus.d_wdata : '0;
            r_cnt         <= CNT_LOAD;
            r_state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            // writes hand back zero so d_rdata is clean on a store completion
            r_rdata <= (r_grant.op == OP_RD) ? bus.m_rdata : '0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_proto_err <= 1'b0;
    else if (bus.d_rd_req && bus.d_wr_req) r_proto_err <= 1'b1;
  end

  // Outputs decode directly from registered state so an asynchronous reset
  // silences every control and data output in the same instant.
  assign w_busy     = (r_state == ST_BUSY);
  assign w_resp     = (r_state == ST_RESP);
  assign w_if_ready = w_resp && (r_grant.owner == OWN_IF);
  assign w_d_ready  = w_resp && (r_grant.owner == OWN_D);

  assign bus.m_addr    = w_busy ? r_addr  : '0;
  assign bus.m_wdata   = w_busy ? r_wdata : '0;
  assign bus.m_read    = w_busy && (r_grant.op == OP_RD);
  assign bus.m_write   = w_busy && (r_grant.op == OP_WR) && (r_cnt == '0);
  assign bus.if_ready  = w_if_ready;
  assign bus.if_rdata  = w_if_ready ? r_rdata : '0;
  assign bus.d_ready   = w_d_ready;
  assign bus.d_rdata   = w_d_ready ? r_rdata : '0;
  assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WC = 2;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .STARVE_LIMIT(SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory device: big-endian bytes, combinational read, write at posedge.
  logic [7:0]  mem_b [0:4095] = '{default: 8'h00};
  logic [11:0] ma;
  logic        bd_we = 1'b0;
  logic [11:0] bd_a  = '0;
  logic [31:0] bd_d  = '0;
  assign ma = bus.m_addr[11:0];
  always_comb
    bus.m_rdata = bus.m_read ? {mem_b[ma], mem_b[ma+12'd1], mem_b[ma+12'd2], mem_b[ma+12'd3]} : '0;
  always @(posedge clk) begin
    if (bus.m_write === 1'b1) begin
      mem_b[ma] <= bus.m_wdata[31:24]; mem_b[ma+12'd1] <= bus.m_wdata[23:16];
      mem_b[ma+12'd2] <= bus.m_wdata[15:8]; mem_b[ma+12'd3] <= bus.m_wdata[7:0];
    end else if (bd_we) begin
      mem_b[bd_a] <= bd_d[31:24]; mem_b[bd_a+12'd1] <= bd_d[23:16];
      mem_b[bd_a+12'd2] <= bd_d[15:8]; mem_b[bd_a+12'd3] <= bd_d[7:0];
    end
  end

  // Reference model: word-level view of memory as the requesters expect it.
  logic [31:0] ref_mem [int unsigned];
  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic drop_all();
    bus.if_req = 1'b0; bus.d_rd_req = 1'b0; bus.d_wr_req = 1'b0;
  endtask

  // Issues one access from idle and reports latency (cycles from the
  // presenting cycle to the ready pulse, -1 on timeout), returned data,
  // the cycle in which m_write was seen and the number of m_write cycles.
  task automatic access(input bit use_d, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdat,
                        output int wk, output int nwr);
    @(negedge clk);
    if (use_d) begin
      bus.d_rd_req = rd; bus.d_wr_req = wr; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    lat = -1; wk = -1; nwr = 0; rdat = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.m_write === 1'b1) begin nwr++; if (wk < 0) wk = k; end
      if ((use_d ? bus.d_ready : bus.if_ready) === 1'b1) begin
        lat = k; rdat = use_d ? bus.d_rdata : bus.if_rdata; break;
      end
    end
    drop_all();
  endtask

  task automatic test_reset();
    drop_all();
    bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    // preload word 0 through the memory backdoor while in reset
    @(negedge clk); bd_a = 12'd0; bd_d = 32'hE3A00014; bd_we = 1'b1;
    @(negedge clk); bd_we = 1'b0;
    ref_mem[0] = 32'hE3A00014;
    total++; if ({bus.if_ready, bus.d_ready, bus.m_read, bus.m_write} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {bus.if_ready, bus.d_ready, bus.m_read, bus.m_write}); end
    total++; if ({bus.m_addr, bus.m_wdata, bus.if_rdata, bus.d_rdata} !== 128'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {bus.m_addr, bus.m_wdata, bus.if_rdata, bus.d_rdata}); end
    total++; if (bus.proto_err !== 1'b0) begin
      bad++; $display("FAIL reset_proto got=%b want=0", bus.proto_err); end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({bus.if_ready, bus.d_ready, bus.m_read, bus.m_write, bus.proto_err} !== 5'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b want=00000", {bus.if_ready, bus.d_ready, bus.m_read, bus.m_write, bus.proto_err}); end
  endtask

  task automatic test_fetch();
    int lat, wk, nwr; logic [31:0] rdat;
    access(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, lat, rdat, wk, nwr);
    total++; if (lat !== WC + 1) begin bad++; $display("FAIL fetch_lat got=%0d want=%0d", lat, WC + 1); end
    total++; if (rdat !== ref_rd(0)) begin bad++; $display("FAIL fetch_data got=%h want=%h", rdat, ref_rd(0)); end
    total++; if (nwr !== 0) begin bad++; $display("FAIL fetch_mwrite got=%0d want=0", nwr); end
  endtask

  task automatic test_write_read();
    int lat, wk, nwr; logic [31:0] rdat;
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd8192, lat, rdat, wk, nwr);
    ref_mem[1024] = 32'd8192;
    total++; if (lat !== WC + 1) begin bad++; $display("FAIL wr_lat got=%0d want=%0d", lat, WC + 1); end
    total++; if (wk !== WC) begin bad++; $display("FAIL wr_cycle got=%0d want=%0d", wk, WC); end
    total++; if (nwr !== 1) begin bad++; $display("FAIL wr_pulses got=%0d want=1", nwr); end
    total++; if (rdat !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h want=0", rdat); end
    access(1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, lat, rdat, wk, nwr);
    total++; if (lat !== WC + 1) begin bad++; $display("FAIL rd_lat got=%0d want=%0d", lat, WC + 1); end
    total++; if (rdat !== ref_rd(1024)) begin bad++; $display("FAIL rd_data got=%h want=%h", rdat, ref_rd(1024)); end
    total++; if (nwr !== 0) begin bad++; $display("FAIL rd_mwrite got=%0d want=0", nwr); end
  endtask

  task automatic test_priority();
    int kd = -1, kf = -1; logic [31:0] rd_d = 'x, rd_f = 'x;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    bus.d_rd_req = 1'b1; bus.d_addr = 32'd1024;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.d_ready === 1'b1) begin kd = k; rd_d = bus.d_rdata; bus.d_rd_req = 1'b0; end
      if (bus.if_ready === 1'b1) begin kf = k; rd_f = bus.if_rdata; bus.if_req = 1'b0; break; end
    end
    drop_all();
    total++; if (kd !== WC + 1) begin bad++; $display("FAIL prio_d_lat got=%0d want=%0d", kd, WC + 1); end
    total++; if (rd_d !== ref_rd(1024)) begin bad++; $display("FAIL prio_d_data got=%h want=%h", rd_d, ref_rd(1024)); end
    total++; if (kf !== 2 * (WC + 2) - 1) begin bad++; $display("FAIL prio_f_lat got=%0d want=%0d", kf, 2 * (WC + 2) - 1); end
    total++; if (rd_f !== ref_rd(0)) begin bad++; $display("FAIL prio_f_data got=%h want=%h", rd_f, ref_rd(0)); end
  endtask

  // Fetch held permanently while data requests arrive back to back.
  task automatic test_back_to_back();
    localparam int N = 12;
    bit exp_own [N];
    int cnt = 0, done = 0, prev = 0;
    bit cur_wr; logic [31:0] cur_a, cur_wd;
    // expected owner order from the starvation rule (1 = data, 0 = fetch)
    for (int i = 0; i < N; i++) begin
      if (cnt < SL) begin exp_own[i] = 1'b1; cnt = (cnt + 1 > SL) ? SL : cnt + 1; end
      else begin exp_own[i] = 1'b0; cnt = 0; end
    end
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    cur_wr = 1'($urandom_range(0, 1)); cur_a = 32'd1040 + 4 * $urandom_range(0, 7); cur_wd = $urandom;
    bus.d_wr_req = cur_wr; bus.d_rd_req = ~cur_wr; bus.d_addr = cur_a; bus.d_wdata = cur_wd;
    for (int k = 1; k <= 100 && done < N; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.d_ready === 1'b1 || bus.if_ready === 1'b1) begin
        total++; if (bus.d_ready !== exp_own[done]) begin
          bad++; $display("FAIL b2b_owner[%0d] got_d=%b want_d=%b", done, bus.d_ready, exp_own[done]); end
        total++; if (k - prev !== ((done == 0) ? WC + 1 : WC + 2)) begin
          bad++; $display("FAIL b2b_gap[%0d] got=%0d want=%0d", done, k - prev, (done == 0) ? WC + 1 : WC + 2); end
        prev = k;
        if (bus.d_ready === 1'b1) begin
          total++; if (bus.d_rdata !== (cur_wr ? 32'h0 : ref_rd(cur_a))) begin
            bad++; $display("FAIL b2b_ddata[%0d] got=%h want=%h", done, bus.d_rdata, cur_wr ? 32'h0 : ref_rd(cur_a)); end
          if (cur_wr) ref_mem[cur_a] = cur_wd;
          cur_wr = 1'($urandom_range(0, 1)); cur_a = 32'd1040 + 4 * $urandom_range(0, 7); cur_wd = $urandom;
          bus.d_wr_req = cur_wr; bus.d_rd_req = ~cur_wr; bus.d_addr = cur_a; bus.d_wdata = cur_wd;
        end else begin
          total++; if (bus.if_rdata !== ref_rd(0)) begin
            bad++; $display("FAIL b2b_fdata[%0d] got=%h want=%h", done, bus.if_rdata, ref_rd(0)); end
        end
        done++;
      end
    end
    drop_all();
    total++; if (done !== N) begin bad++; $display("FAIL b2b_timeout got=%0d want=%0d", done, N); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nwr = 0, nrdy = 0, lat, wk, nw2; logic [31:0] rdat;
    @(negedge clk);
    bus.d_wr_req = 1'b1; bus.d_addr = 32'd1028; bus.d_wdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    if (bus.m_write === 1'b1) nwr++;
    rst = 1'b1;
    #1;
    total++; if ({bus.d_ready, bus.m_write, bus.m_read, bus.m_addr} !== 35'h0) begin
      bad++; $display("FAIL midrst_out got=%h want=0", {bus.d_ready, bus.m_write, bus.m_read, bus.m_addr}); end
    drop_all();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (bus.m_write === 1'b1) nwr++;
      if (bus.d_ready === 1'b1) nrdy++;
    end
    total++; if (nwr !== 0) begin bad++; $display("FAIL midrst_mwrite got=%0d want=0", nwr); end
    total++; if (nrdy !== 0) begin bad++; $display("FAIL midrst_ready got=%0d want=0", nrdy); end
    access(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, lat, rdat, wk, nw2);
    total++; if (rdat !== ref_rd(1028)) begin bad++; $display("FAIL midrst_mem got=%h want=%h", rdat, ref_rd(1028)); end
    total++; if (lat !== WC + 1) begin bad++; $display("FAIL midrst_lat got=%0d want=%0d", lat, WC + 1); end
  endtask

  task automatic test_proto();
    int lat, wk, nwr; logic [31:0] rdat;
    access(1'b1, 1'b1, 1'b1, 32'd1032, 32'h80000000, lat, rdat, wk, nwr);
    ref_mem[1032] = 32'h80000000;
    total++; if (nwr !== 1) begin bad++; $display("FAIL proto_wr got=%0d want=1", nwr); end
    total++; if (bus.proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%b want=1", bus.proto_err); end
    access(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, lat, rdat, wk, nwr);
    total++; if (rdat !== ref_rd(1032)) begin bad++; $display("FAIL proto_rd got=%h want=%h", rdat, ref_rd(1032)); end
    access(1'b0, 1'b0, 1'b0, 32'd1032, 32'd0, lat, rdat, wk, nwr);
    total++; if (rdat !== ref_rd(1032)) begin bad++; $display("FAIL proto_fetch got=%h want=%h", rdat, ref_rd(1032)); end
    total++; if (bus.proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b want=1", bus.proto_err); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (bus.proto_err !== 1'b0) begin bad++; $display("FAIL proto_clear got=%b want=0", bus.proto_err); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_proto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
